// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and constants for the mux4_rr_arbiter block.
// Optional feature macro used by the block: ARB_TIMEOUT_EN (grant hold limit).
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  localparam logic [SEL_W-1:0] SEL_A = 2'd0;
  localparam logic [SEL_W-1:0] SEL_B = 2'd1;
  localparam logic [SEL_W-1:0] SEL_C = 2'd2;
  localparam logic [SEL_W-1:0] SEL_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle of the shared mux arbiter.
// The arbiter uses the slave modport; the producer/consumer side uses master.
interface mux4_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) ();

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] last;
  logic [WIDTH-1:0]   data_a;
  logic [WIDTH-1:0]   data_b;
  logic [WIDTH-1:0]   data_c;
  logic [WIDTH-1:0]   data_d;
  logic               out_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   select;
  logic               enable;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               timeout;

  modport slave (
    input  req, last, data_a, data_b, data_c, data_d, out_ready,
    output out_valid, out_data, select, enable, grant, busy, timeout
  );

  modport master (
    output req, last, data_a, data_b, data_c, data_d, out_ready,
    input  out_valid, out_data, select, enable, grant, busy, timeout
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set request starting at ptr, wrapping mod 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               found
);

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    logic [SEL_W-1:0] cand;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux with burst hold and valid/ready output.
// Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles (timeout pulse).
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic              clk,
  input  logic              reset,
  mux4_rr_arbiter_if.slave  bus
);

  state_t             state, state_next;
  logic [SEL_W-1:0]   ptr, ptr_next;
  logic [SEL_W-1:0]   select_q, select_next;
  logic               enable_q, enable_next;
  logic [NUM_REQ-1:0] grant_q, grant_next;
  logic               busy_q, busy_next;
  logic               timeout_q, timeout_next;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_found;
  logic               owner_req;
  logic               owner_done;
  logic               hold_limit;

  rr_pick u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner finishes on a last-beat transfer or by withdrawing its request.
  assign owner_req  = bus.req[select_q];
  assign owner_done = !owner_req || (bus.out_ready && bus.last[select_q]);

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = 8;
  logic [HOLD_W-1:0] hold_cnt, hold_next;

  // Limit is hit on the edge that would bring the GRANT-cycle count to MAX_HOLD.
  assign hold_limit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // Grant hold counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_cnt <= '0;
    else       hold_cnt <= hold_next;
  end
`else
  // No hold bound: MAX_HOLD is irrelevant and the limit never fires.
  assign hold_limit = (MAX_HOLD == 0) & 1'b0;
`endif

  // State and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= SEL_A;
      select_q  <= SEL_A;
      enable_q  <= 1'b0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      select_q  <= select_next;
      enable_q  <= enable_next;
      grant_q   <= grant_next;
      busy_q    <= busy_next;
      timeout_q <= timeout_next;
    end
  end

  // Next-state: grant from IDLE by rotating priority, release from GRANT.
  always_comb begin
    state_next   = state;
    ptr_next     = ptr;
    select_next  = select_q;
    enable_next  = enable_q;
    grant_next   = grant_q;
    busy_next    = busy_q;
    timeout_next = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_next    = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next  = GRANT;
          select_next = pick_idx;
          grant_next  = onehot(pick_idx);
          enable_next = 1'b1;
          busy_next   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_next   = '0;
`endif
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        hold_next = hold_cnt + HOLD_W'(1);
`endif
        if (owner_done || hold_limit) begin
          state_next   = IDLE;
          ptr_next     = select_q + SEL_W'(1);
          grant_next   = '0;
          enable_next  = 1'b0;
          busy_next    = 1'b0;
          timeout_next = !owner_done;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output mux: data path follows the registered select while enabled.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    if (enable_q) begin
      bus.out_valid = owner_req;
      case (select_q)
        SEL_A: bus.out_data = bus.data_a;
        SEL_B: bus.out_data = bus.data_b;
        SEL_C: bus.out_data = bus.data_c;
        SEL_D: bus.out_data = bus.data_d;
      endcase
    end
  end

  assign bus.select  = select_q;
  assign bus.enable  = enable_q;
  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule
